// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared bus constants and the OAM DMA state encoding.
//   REG_DMA         CPU-visible DMA start / source-page register address
//   OAM_BASE        first OAM byte on the master-side bus
//   OAM_SIZE        number of OAM bytes copied per transfer
//   ST_*            FSM state encoding used by oam_dma
//   echo_page()     folds echo-RAM source pages onto the work-RAM they mirror
// -----------------------------------------------------------------------------
package oam_dma_pkg;

  localparam logic [15:0] REG_DMA  = 16'hFF46;
  localparam logic [15:0] OAM_BASE = 16'hFE00;
  localparam logic [7:0]  OAM_SIZE = 8'hA0;

  // Index of the last OAM byte; the transfer ends after writing it.
  localparam logic [7:0]  LAST_INDEX = OAM_SIZE - 8'd1;

  // Pages 0xE0..0xFF are echo RAM, an alias of 0xC0..0xDF.
  localparam logic [7:0]  ECHO_FIRST_PAGE = 8'hE0;
  localparam logic [7:0]  ECHO_OFFSET     = 8'h20;

  localparam logic [2:0]  ST_IDLE  = 3'd0;
  localparam logic [2:0]  ST_DELAY = 3'd1;
  localparam logic [2:0]  ST_READ  = 3'd2;
  localparam logic [2:0]  ST_WAIT  = 3'd3;
  localparam logic [2:0]  ST_WRITE = 3'd4;

  function automatic logic [7:0] echo_page(input logic [7:0] page);
    return (page >= ECHO_FIRST_PAGE) ? (page - ECHO_OFFSET) : page;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// Copies 160 bytes from page {src_page, 0x00..0x9F} into OAM at 0xFE00..0xFE9F
// after the CPU writes the source page to 0xFF46. Each byte takes three cycles
// (READ address, WAIT for read data, WRITE to OAM) after a one-cycle DELAY.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   mem_addr            CPU bus address (snooped)
//   mem_data_write      CPU bus write data
//   mem_do_write        CPU bus write strobe
//   mem_data_read       source-page register readback (0xFF when not selected)
//   mem_data_active     high when a CPU read targets 0xFF46
//   dma_addr            master-side address
//   dma_data_read       master-side read data, valid one cycle after dma_addr
//   dma_data_write      master-side write data
//   dma_do_write        master-side write strobe
//   dma_busy            block owns the bus (arbiter muxes dma_* when high)
//   dma_done            one-cycle pulse after the final OAM write
// -----------------------------------------------------------------------------
module oam_dma
  import oam_dma_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_data_write,
  input  logic        mem_do_write,
  output logic [7:0]  mem_data_read,
  output logic        mem_data_active,
  output logic [15:0] dma_addr,
  input  logic [7:0]  dma_data_read,
  output logic [7:0]  dma_data_write,
  output logic        dma_do_write,
  output logic        dma_busy,
  output logic        dma_done
);

  logic [2:0] state;
  logic [7:0] src_page;
  logic [7:0] index;
  logic [7:0] byte_reg;
  logic       reg_hit;
  logic       start;

  assign reg_hit         = (mem_addr == REG_DMA);
  assign start           = mem_do_write && reg_hit;
  assign mem_data_active = !mem_do_write && reg_hit;
  assign mem_data_read   = mem_data_active ? src_page : 8'hFF;
  assign dma_busy        = (state != ST_IDLE);

  // A start write wins over every state, including the final WRITE, so a
  // restart never produces a done pulse and always re-enters DELAY.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      src_page <= 8'h00;
      index    <= 8'h00;
      byte_reg <= 8'h00;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      if (start) begin
        src_page <= mem_data_write;
        index    <= 8'h00;
        state    <= ST_DELAY;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_DELAY: begin
            index <= 8'h00;
            state <= ST_READ;
          end
          ST_READ: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            // Source data arrives one cycle after the READ address.
            byte_reg <= dma_data_read;
            state    <= ST_WRITE;
          end
          ST_WRITE: begin
            index <= index + 8'd1;
            if (index < LAST_INDEX) begin
              state <= ST_READ;
            end else begin
              state    <= ST_IDLE;
              dma_done <= 1'b1;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    dma_addr       = 16'h0000;
    dma_data_write = 8'h00;
    dma_do_write   = 1'b0;
    case (state)
      ST_READ, ST_WAIT: begin
        dma_addr = {echo_page(src_page), index};
      end
      ST_WRITE: begin
        dma_addr       = OAM_BASE + {8'h00, index};
        dma_data_write = byte_reg;
        dma_do_write   = 1'b1;
      end
      default: begin
        dma_addr = 16'h0000;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma.sv
// -----------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A transfer model tracks only "active" and
// the number of edges since the start edge; every cycle's expected bus
// activity is derived from that count with plain arithmetic (one cycle of
// delay, then three cycles per byte). A registered memory model answers reads
// with mem_val(addr).
// -----------------------------------------------------------------------------
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] mem_addr = 16'h0000;
  logic [7:0]  mem_data_write = 8'h00;
  logic        mem_do_write = 1'b0;
  logic [7:0]  mem_data_read;
  logic        mem_data_active;
  logic [15:0] dma_addr;
  logic [7:0]  dma_data_read = 8'h00;
  logic [7:0]  dma_data_write;
  logic        dma_do_write;
  logic        dma_busy;
  logic        dma_done;

  oam_dma dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_do_write   (mem_do_write),
    .mem_data_read  (mem_data_read),
    .mem_data_active(mem_data_active),
    .dma_addr       (dma_addr),
    .dma_data_read  (dma_data_read),
    .dma_data_write (dma_data_write),
    .dma_do_write   (dma_do_write),
    .dma_busy       (dma_busy),
    .dma_done       (dma_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Page 0xC1 yields i ^ 0x5A; other pages give distinct contents.
  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
  endfunction

  function automatic logic [7:0] mirror(input logic [7:0] p);
    return (p >= 8'hE0) ? (p - 8'h20) : p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Registered source memory: data valid one cycle after the address.
  always @(posedge clk) dma_data_read <= mem_val(dma_addr);

  // Transfer model.
  wire m_start = mem_do_write && (mem_addr == 16'hFF46);
  bit         m_active  = 1'b0;
  int         m_elapsed = 0;
  logic [7:0] m_reg     = 8'h00;
  bit         m_done    = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active  <= 1'b0;
      m_elapsed <= 0;
      m_reg     <= 8'h00;
      m_done    <= 1'b0;
    end else begin
      m_done <= m_active && (m_elapsed == 480) && !m_start;
      if (m_start) begin
        m_reg     <= mem_data_write;
        m_active  <= 1'b1;
        m_elapsed <= 0;
      end else if (m_active) begin
        if (m_elapsed == 480) begin
          m_active  <= 1'b0;
          m_elapsed <= 0;
        end else begin
          m_elapsed <= m_elapsed + 1;
        end
      end
    end
  end

  // Observed OAM image and event counters.
  logic [7:0] oam [0:159];
  int n_busy = 0;
  int n_done = 0;
  int n_wr   = 0;

  // Compare process: all outputs, every cycle, on the falling edge.
  always @(negedge clk) begin
    logic [15:0] e_addr;
    logic [7:0]  e_dw;
    logic        e_dow;
    logic        e_act;
    logic [7:0]  pg;
    int          ph;
    int          idx;
    bit          chk_bus;
    e_addr  = 16'h0000;
    e_dw    = 8'h00;
    e_dow   = 1'b0;
    chk_bus = 1'b1;
    if (m_active && m_elapsed == 0) begin
      chk_bus = 1'b0;
    end else if (m_active) begin
      ph  = (m_elapsed - 1) % 3;
      idx = (m_elapsed - 1) / 3;
      pg  = mirror(m_reg);
      if (ph < 2) begin
        e_addr = {pg, 8'(idx)};
      end else begin
        e_addr = 16'hFE00 + 16'(idx);
        e_dw   = mem_val({pg, 8'(idx)});
        e_dow  = 1'b1;
      end
    end
    check("busy", dma_busy, m_active);
    check("done", dma_done, m_done);
    check("do_write", dma_do_write, e_dow);
    if (chk_bus) begin
      check("dma_addr", dma_addr, e_addr);
      check("dma_data_write", dma_data_write, e_dw);
    end
    e_act = !mem_do_write && (mem_addr == 16'hFF46);
    check("mem_data_active", mem_data_active, e_act);
    check("mem_data_read", mem_data_read, e_act ? m_reg : 8'hFF);

    if (dma_busy) n_busy++;
    if (dma_done) n_done++;
    if (dma_do_write && dma_addr >= 16'hFE00 && dma_addr <= 16'hFE9F) begin
      oam[dma_addr - 16'hFE00] = dma_data_write;
      n_wr++;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    mem_addr       = a;
    mem_data_write = d;
    mem_do_write   = 1'b1;
    step();
    mem_do_write   = 1'b0;
    mem_addr       = 16'h0000;
  endtask

  task automatic clear_counts();
    n_busy = 0;
    n_done = 0;
    n_wr   = 0;
    for (int i = 0; i < 160; i++) oam[i] = 8'hEE;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (dma_busy && n < 1200) begin
      step();
      n++;
    end
    check(name, dma_busy, 1'b0);
  endtask

  task automatic check_oam(input string name, input logic [7:0] page);
    int errs;
    errs = 0;
    for (int i = 0; i < 160; i++)
      if (oam[i] !== mem_val({mirror(page), 8'(i)})) errs++;
    check(name, errs, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    reset_n = 1'b0;
    repeat (3) step();
    check("rst_busy", dma_busy, 1'b0);
    check("rst_done", dma_done, 1'b0);
    check("rst_do_write", dma_do_write, 1'b0);
    check("rst_addr", dma_addr, 16'h0000);
    reset_n = 1'b1;
    repeat (5) step();
    check("idle_after_reset", dma_busy, 1'b0);

    // Basic transfer from page 0xC1.
    clear_counts();
    cpu_write(16'hFF46, 8'hC1);
    wait_idle("timeout_c1");
    repeat (2) step();
    check("c1_busy_cycles", n_busy, 481);
    check("c1_done_count", n_done, 1);
    check("c1_write_count", n_wr, 160);
    check("c1_oam0", oam[0], 8'h5A);
    check("c1_oam159", oam[159], 8'hC5);
    check_oam("c1_oam_all", 8'hC1);

    // Register readback.
    cpu_write(16'hFF46, 8'h80);
    mem_addr = 16'hFF46;
    #1;
    check("rd_ff46_active", mem_data_active, 1'b1);
    check("rd_ff46_data", mem_data_read, 8'h80);
    mem_addr = 16'hFF45;
    #1;
    check("rd_ff45_active", mem_data_active, 1'b0);
    check("rd_ff45_data", mem_data_read, 8'hFF);
    mem_addr = 16'h0000;
    wait_idle("timeout_80");
    cpu_write(16'hFF45, 8'h55);
    step();
    check("ignored_write_busy", dma_busy, 1'b0);
    mem_addr = 16'hFF46;
    #1;
    check("ignored_write_reg", mem_data_read, 8'h80);
    mem_addr = 16'h0000;

    // Restart at cycle 100.
    clear_counts();
    cpu_write(16'hFF46, 8'hC0);
    repeat (99) step();
    mem_addr = 16'hFF46; mem_data_write = 8'hD0; mem_do_write = 1'b1;
    n_busy = 0;
    n_wr   = 0;
    for (int i = 0; i < 160; i++) oam[i] = 8'hEE;
    step();
    mem_do_write = 1'b0; mem_addr = 16'h0000;
    wait_idle("timeout_restart");
    repeat (2) step();
    check("restart_busy_cycles", n_busy, 481);
    check("restart_done_count", n_done, 1);
    check("restart_write_count", n_wr, 160);
    check("restart_oam0", oam[0], 8'h4B);
    check_oam("restart_oam_all", 8'hD0);

    // Echo page 0xF2 reads from 0xD2xx.
    clear_counts();
    cpu_write(16'hFF46, 8'hF2);
    step();
    check("echo_first_read_addr", dma_addr, 16'hD200);
    wait_idle("timeout_echo");
    check("echo_oam0", oam[0], 8'h49);
    check_oam("echo_oam_all", 8'hF2);

    // Reset at cycle 200 of a transfer.
    clear_counts();
    cpu_write(16'hFF46, 8'hC1);
    repeat (199) step();
    reset_n = 1'b0;
    #1;
    check("abort_busy", dma_busy, 1'b0);
    check("abort_do_write", dma_do_write, 1'b0);
    n_wr   = 0;
    n_done = 0;
    repeat (3) step();
    reset_n = 1'b1;
    repeat (500) step();
    check("abort_no_writes", n_wr, 0);
    check("abort_no_done", n_done, 0);
    mem_addr = 16'hFF46;
    #1;
    check("abort_reg_cleared", mem_data_read, 8'h00);
    mem_addr = 16'h0000;

    // Start write on the final WRITE cycle.
    clear_counts();
    cpu_write(16'hFF46, 8'hC1);
    begin
      int n;
      n = 0;
      while (!(m_active && m_elapsed == 480) && n < 600) begin
        step();
        n++;
      end
      check("final_write_reached", n < 600, 1'b1);
    end
    check("final_write_addr", dma_addr, 16'hFE9F);
    check("final_write_strobe", dma_do_write, 1'b1);
    mem_addr = 16'hFF46; mem_data_write = 8'h30; mem_do_write = 1'b1;
    n_busy = 0;
    n_done = 0;
    step();
    mem_do_write = 1'b0; mem_addr = 16'h0000;
    check("collide_no_done", dma_done, 1'b0);
    check("collide_busy", dma_busy, 1'b1);
    check("collide_delay_strobe", dma_do_write, 1'b0);
    wait_idle("timeout_collide");
    repeat (2) step();
    check("collide_busy_cycles", n_busy, 481);
    check("collide_done_count", n_done, 1);
    check_oam("collide_oam_all", 8'h30);

    // Randomized traffic with occasional restarts, checked every cycle.
    for (int t = 0; t < 16; t++) begin
      int len;
      cpu_write(16'hFF46, 8'($urandom));
      len = $urandom_range(50, 600);
      for (int c = 0; c < len; c++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r == 0) begin
          cpu_write(16'hFF46, 8'($urandom));
        end else if (r < 15) begin
          logic [15:0] a;
          a = 16'($urandom);
          if (a == 16'hFF46) a = 16'hFF47;
          cpu_write(a, 8'($urandom));
        end else if (r < 30) begin
          mem_addr = (r < 22) ? 16'hFF46 : 16'($urandom);
          step();
          mem_addr = 16'h0000;
        end else begin
          step();
        end
      end
      wait_idle("timeout_random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 The block SHALL provide these ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mem_addr  input  16  CPU bus address (snooped).
- mem_data_write  input  8  CPU bus write data.
- mem_do_write  input  1  CPU bus write strobe.
- mem_data_read  output  8  read data for 0xFF46.
- mem_data_active  output  1  high when this block drives mem_data_read.
- dma_addr  output  16  master-side bus address.
- dma_data_read  input  8  master-side read data, valid one cycle after dma_addr.
- dma_data_write  output  8  master-side write data.
- dma_do_write  output  1  master-side write strobe.
- dma_busy  output  1  high while the block owns the bus; the arbiter muxes dma_* onto the bus when high.
- dma_done  output  1  one-cycle pulse after the final OAM write.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.

Function
REQ-003 A CPU write (mem_do_write=1, mem_addr=0xFF46) SHALL latch mem_data_write into the source-page register and start a transfer on the next edge.
REQ-004 mem_data_active SHALL be high exactly when mem_do_write=0 and mem_addr=0xFF46.
REQ-005 When mem_data_active=1, mem_data_read SHALL equal the source-page register; otherwise it SHALL be 0xFF.
REQ-006 The FSM SHALL have the states IDLE, DELAY, READ, WAIT and WRITE.
REQ-007 The FSM SHALL follow these transitions:
- IDLE to DELAY on a start write.
- DELAY to READ after 1 cycle.
- READ to WAIT to WRITE, one cycle each.
- WRITE to READ if index < 159, else to IDLE.
REQ-008 In READ and WAIT, dma_addr SHALL be {src_page, index} and dma_do_write SHALL be 0.
REQ-009 At the end of WAIT, dma_data_read SHALL be captured into an 8-bit byte register.
REQ-010 In WRITE, dma_addr SHALL be 0xFE00+index, dma_data_write SHALL be the byte register, and dma_do_write SHALL be 1.
REQ-011 index SHALL be 8 bits, SHALL clear in DELAY, and SHALL increment on leaving WRITE.
REQ-012 The transfer SHALL cover 160 bytes (index 0..159), and the OAM address SHALL never exceed 0xFE9F.
REQ-013 Source pages 0xE0–0xFF SHALL be mirrored to page−0x20 (echo RAM); pages 0x00–0xDF SHALL be used unmodified.
REQ-014 dma_busy SHALL be high in every non-IDLE state.
REQ-015 Total busy time from the start edge SHALL be 1 + 160×3 = 481 cycles.
REQ-016 dma_done SHALL pulse high for exactly one cycle on the WRITE-to-IDLE transition edge.
REQ-017 A start write while busy SHALL restart the transfer: latch the new page, go to DELAY, and clear index; any in-flight byte is discarded and the restart is not a done.
REQ-018 A start write coincident with the final WRITE SHALL take priority: no dma_done pulse, and the next state is DELAY.
REQ-019 In IDLE, dma_addr SHALL be 0x0000, dma_data_write SHALL be 0x00, and dma_do_write SHALL be 0.
REQ-020 Writes to any address other than 0xFF46 SHALL be ignored.

Reset
REQ-021 Asserting reset_n=0 SHALL immediately force state to IDLE, src_page to 0x00, index to 0, and the byte register to 0x00.
REQ-022 During and after reset, dma_busy, dma_done and dma_do_write SHALL read 0.
REQ-023 Reset asserted mid-transfer SHALL abort it with no further OAM writes and no dma_done pulse.
REQ-024 After reset release, the block SHALL stay in IDLE until a start write occurs.

Structure
REQ-025 The shared bus package SHALL hold these constants:
- REG_DMA = 0xFF46.
- OAM_BASE = 0xFE00.
- OAM_SIZE = 0xA0.
- The FSM state encoding.
REQ-026 The block SHALL be a single module with no sub-module.
REQ-027 The master-side mux SHALL live in the existing bus arbiter, keyed on dma_busy.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Write 0xC1 to 0xFF46 with a memory model holding 0xC100+i = i^0x5A -> OAM[i] = i^0x5A for i = 0..159; dma_busy high for 481 cycles; one dma_done pulse.
- Read 0xFF46 after writing 0x80 -> mem_data_active=1 and mem_data_read=0x80; read 0xFF45 -> mem_data_active=0 and mem_data_read=0xFF.
- Write 0xC0, then write 0xD0 at cycle 100 -> transfer restarts with index 0; final OAM contents come from 0xD000–0xD09F; exactly one dma_done, 481 cycles after the second write.
- Write 0xF2 -> reads come from 0xD200–0xD29F.
- Assert reset_n=0 at cycle 200 of a transfer -> dma_busy=0 and dma_do_write=0 immediately; no further writes to 0xFE00–0xFE9F; no dma_done.
- Start write on the final WRITE cycle -> no dma_done on that edge; state = DELAY; full new transfer follows.
